// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_pkg;

    typedef enum logic [1:0] {
        WAIT_RISE,
        HIGH,
        LOW,
        STUCK
    } state_e;

    localparam int DUTY_W_DEF = 10;
    localparam int DUTY_FULL  = 1023;
    localparam int CLK_HZ     = 100_000_000;

endpackage

// File: rtl/pwm_duty_div.sv
// Restoring divider yielding floor(num*2^QW/den); requires num < den.
// One quotient bit per cycle, done pulses QW+1 cycles after start.
module pwm_duty_div
    import pwm_pkg::*;
#(
    parameter int QW = DUTY_W_DEF,
    parameter int DW = 14
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [DW-1:0] num_i,
    input  logic [DW-1:0] den_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [QW-1:0] quot_o
);

    localparam int CW = $clog2(QW + 1);

    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] den_q, den_d;
    logic [QW-1:0] quot_q, quot_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW:0]   sh;
    logic [DW-1:0] diff;

    always_comb begin
        rem_d  = rem_q;
        den_d  = den_q;
        quot_d = quot_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        sh     = {rem_q, 1'b0};
        diff   = sh[DW-1:0] - den_q;
        if (abort_i) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start_i && !busy_q) begin
            rem_d  = num_i;
            den_d  = den_i;
            quot_d = '0;
            cnt_d  = CW'(QW);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q != '0) begin
                // remainder stays below den, so the low DW bits of the
                // difference are exact whenever the subtraction is taken
                if (sh >= {1'b0, den_q}) begin
                    rem_d  = diff;
                    quot_d = {quot_q[QW-2:0], 1'b1};
                end else begin
                    rem_d  = sh[DW-1:0];
                    quot_d = {quot_q[QW-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
            end else begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            den_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            den_q  <= den_d;
            quot_q <= quot_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign quot_o = quot_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM duty/period capture with stuck-line detection.
// Define PWM_CAPTURE_AVG_EN to report a 4-result moving average of duty.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int DUTY_W         = DUTY_W_DEF,
    parameter int MAX_PERIOD_CYC = 8192,
    parameter int CNT_W          = 14,
    parameter int SYNC_STAGES    = 2
) (
    input  logic              c100MHz,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic [CNT_W-1:0]  period,
    output logic              duty_valid,
    output logic              stuck_hi,
    output logic              stuck_lo,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(MAX_PERIOD_CYC);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   prime_q;
    logic                   s_prev_q;
    logic [CNT_W-1:0]       hi_q, hi_d, lo_q, lo_d;
    logic [CNT_W-1:0]       pend_q, pend_d;
    logic [DUTY_W-1:0]      duty_q, duty_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   dv_q, dv_d, ovr_q, ovr_d;
    logic                   sthi_q, sthi_d, stlo_q, stlo_d;

    logic              s, armed, rise, fall;
    logic [CNT_W-1:0]  hi_inc, lo_inc, p_sat;
    logic [CNT_W:0]    p_sum;
    logic              complete, tmo_hi, tmo_lo;
    logic              div_start, div_busy, div_done;
    logic [DUTY_W-1:0] div_quot;

`ifdef PWM_CAPTURE_AVG_EN
    logic [DUTY_W-1:0] hist_q [3];
    logic [DUTY_W-1:0] hist_d [3];
    logic [1:0]        navg_q, navg_d;
    logic [DUTY_W+1:0] avg_sum;
`endif

    // edges stay masked until the sync chain and s_prev hold real pin data
    assign s      = sync_q[SYNC_STAGES-1];
    assign armed  = prime_q[SYNC_STAGES];
    assign rise   = armed & s & ~s_prev_q;
    assign fall   = armed & ~s & s_prev_q;
    assign hi_inc = (hi_q == CNT_MAX) ? hi_q : hi_q + 1'b1;
    assign lo_inc = (lo_q == CNT_MAX) ? lo_q : lo_q + 1'b1;
    assign p_sum  = {1'b0, hi_q} + {1'b0, lo_q};
    assign p_sat  = p_sum[CNT_W] ? CNT_MAX : p_sum[CNT_W-1:0];

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        duty_d    = duty_q;
        period_d  = period_q;
        dv_d      = 1'b0;
        ovr_d     = 1'b0;
        sthi_d    = sthi_q;
        stlo_d    = stlo_q;
        complete  = 1'b0;
        tmo_hi    = 1'b0;
        tmo_lo    = 1'b0;
        div_start = 1'b0;
`ifdef PWM_CAPTURE_AVG_EN
        hist_d  = hist_q;
        navg_d  = navg_q;
        avg_sum = {2'b00, div_quot} + {2'b00, hist_q[0]}
                + {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
`endif

        if (div_done) begin
            period_d = pend_q;
`ifdef PWM_CAPTURE_AVG_EN
            hist_d[0] = div_quot;
            hist_d[1] = hist_q[0];
            hist_d[2] = hist_q[1];
            if (navg_q == 2'd3) begin
                duty_d = DUTY_W'(avg_sum >> 2);
                dv_d   = 1'b1;
            end else begin
                navg_d = navg_q + 1'b1;
            end
`else
            duty_d = div_quot;
            dv_d   = 1'b1;
`endif
        end

        unique case (state_q)
            WAIT_RISE: begin
                if (rise) begin
                    hi_d    = ONE;
                    state_d = HIGH;
                end else if (lo_q >= TMO) begin
                    tmo_lo = 1'b1;
                end else if (armed) begin
                    lo_d = s ? '0 : lo_inc;
                end
            end
            HIGH: begin
                if (fall) begin
                    lo_d    = ONE;
                    state_d = LOW;
                end else if (hi_q >= TMO) begin
                    tmo_hi = 1'b1;
                end else begin
                    hi_d = hi_inc;
                end
            end
            LOW: begin
                if (rise) begin
                    complete = 1'b1;
                    hi_d     = ONE;
                    state_d  = HIGH;
                end else if (lo_q >= TMO) begin
                    tmo_lo = 1'b1;
                end else begin
                    lo_d = lo_inc;
                end
            end
            STUCK: begin
                if (rise) begin
                    sthi_d  = 1'b0;
                    stlo_d  = 1'b0;
                    hi_d    = ONE;
                    state_d = HIGH;
                end else if (fall && sthi_q) begin
                    sthi_d  = 1'b0;
                    lo_d    = '0;
                    state_d = WAIT_RISE;
                end
            end
            default: state_d = WAIT_RISE;
        endcase

        if (complete) begin
            if (div_busy) begin
                ovr_d = 1'b1;
            end else begin
                div_start = 1'b1;
                pend_d    = p_sat;
            end
        end

        // a timeout overrides any divider result landing this cycle
        if (tmo_hi || tmo_lo) begin
            state_d  = STUCK;
            sthi_d   = tmo_hi;
            stlo_d   = tmo_lo;
            duty_d   = tmo_hi ? '1 : '0;
            period_d = '0;
            dv_d     = 1'b1;
`ifdef PWM_CAPTURE_AVG_EN
            navg_d = '0;
`endif
        end
    end

    always_ff @(posedge c100MHz or posedge rst) begin
        if (rst) begin
            state_q  <= WAIT_RISE;
            sync_q   <= '0;
            prime_q  <= '0;
            s_prev_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            pend_q   <= '0;
            duty_q   <= '0;
            period_q <= '0;
            dv_q     <= 1'b0;
            ovr_q    <= 1'b0;
            sthi_q   <= 1'b0;
            stlo_q   <= 1'b0;
`ifdef PWM_CAPTURE_AVG_EN
            hist_q <= '{default: '0};
            navg_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            prime_q  <= {prime_q[SYNC_STAGES-1:0], 1'b1};
            s_prev_q <= s;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            pend_q   <= pend_d;
            duty_q   <= duty_d;
            period_q <= period_d;
            dv_q     <= dv_d;
            ovr_q    <= ovr_d;
            sthi_q   <= sthi_d;
            stlo_q   <= stlo_d;
`ifdef PWM_CAPTURE_AVG_EN
            hist_q <= hist_d;
            navg_q <= navg_d;
`endif
        end
    end

    pwm_duty_div #(
        .QW(DUTY_W),
        .DW(CNT_W)
    ) u_div (
        .clk_i  (c100MHz),
        .rst_i  (rst),
        .start_i(div_start),
        .abort_i(tmo_hi | tmo_lo),
        .num_i  (hi_q),
        .den_i  (p_sat),
        .busy_o (div_busy),
        .done_o (div_done),
        .quot_o (div_quot)
    );

    assign duty       = duty_q;
    assign period     = period_q;
    assign duty_valid = dv_q;
    assign stuck_hi   = sthi_q;
    assign stuck_lo   = stlo_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with hand-computed expectations.
module tb_pwm_capture;

    logic        c100MHz = 1'b0;
    logic        rst;
    logic        pwm_in;
    logic [9:0]  duty;
    logic [13:0] period;
    logic        duty_valid;
    logic        stuck_hi;
    logic        stuck_lo;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int dv_cnt = 0;
    int ovr_cnt = 0;
    int dv_base = 0;
    int ovr_base = 0;
    logic [9:0] last_duty = '0;

    always #5 c100MHz = ~c100MHz;

    pwm_capture dut (
        .c100MHz   (c100MHz),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .duty      (duty),
        .period    (period),
        .duty_valid(duty_valid),
        .stuck_hi  (stuck_hi),
        .stuck_lo  (stuck_lo),
        .overrun   (overrun)
    );

    always @(negedge c100MHz) begin
        if (duty_valid) begin
            dv_cnt++;
            last_duty = duty;
        end
        if (overrun) ovr_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge c100MHz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic mark();
        dv_base  = dv_cnt;
        ovr_base = ovr_cnt;
    endtask

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        step(3);
        check("rst_duty", 32'(duty), 0);
        check("rst_period", 32'(period), 0);
        check("rst_dv", 32'(duty_valid), 0);
        check("rst_sthi", 32'(stuck_hi), 0);
        check("rst_stlo", 32'(stuck_lo), 0);
        check("rst_ovr", 32'(overrun), 0);
        rst = 1'b0;
        step(10);

`ifdef PWM_CAPTURE_AVG_EN
        mark();
        pwm_in = 1'b1; step(1000); pwm_in = 1'b0; step(3000);
        pwm_in = 1'b1; step(1000); pwm_in = 1'b0; step(3000);
        pwm_in = 1'b1; step(2000); pwm_in = 1'b0; step(2000);
        pwm_in = 1'b1; step(2000); pwm_in = 1'b0; step(2000);
        pwm_in = 1'b1; step(20);
        check("avg_dv_cnt", 32'(dv_cnt - dv_base), 1);
        check("avg_duty", 32'(last_duty), 384);
        check("avg_period", 32'(period), 4000);
        check("avg_ovr", 32'(ovr_cnt - ovr_base), 0);
`else
        // 1000 high / 3000 low, result 12 cycles after the synced rise
        pwm_in = 1'b1; step(1000);
        pwm_in = 1'b0; step(3000);
        pwm_in = 1'b1; step(14);
        check("t1_dv_early", 32'(duty_valid), 0);
        step(1);
        check("t1_dv", 32'(duty_valid), 1);
        check("t1_duty", 32'(duty), 256);
        check("t1_period", 32'(period), 4000);

        // three 50% periods
        step(1985);
        mark();
        pwm_in = 1'b0; step(2000);
        pwm_in = 1'b1; step(2000);
        pwm_in = 1'b0; step(2000);
        pwm_in = 1'b1; step(2000);
        pwm_in = 1'b0; step(2000);
        pwm_in = 1'b1; step(20);
        check("t2_dv_cnt", 32'(dv_cnt - dv_base), 3);
        check("t2_ovr_cnt", 32'(ovr_cnt - ovr_base), 0);
        check("t2_duty", 32'(last_duty), 512);
        check("t2_period", 32'(period), 4000);

        // held high: timeout once hi_cnt reaches 8192
        step(8174);
        check("t3_sthi_early", 32'(stuck_hi), 0);
        step(1);
        check("t3_sthi", 32'(stuck_hi), 1);
        check("t3_duty", 32'(duty), 1023);
        check("t3_period", 32'(period), 0);
        check("t3_stlo", 32'(stuck_lo), 0);
        step(1805);
        pwm_in = 1'b0; step(10);
        check("t3_sthi_clr", 32'(stuck_hi), 0);
        mark();
        pwm_in = 1'b1; step(1000);
        pwm_in = 1'b0; step(3000);
        pwm_in = 1'b1; step(20);
        check("t3_dv_cnt", 32'(dv_cnt - dv_base), 1);
        check("t3_rec_duty", 32'(duty), 256);
        check("t3_rec_period", 32'(period), 4000);

        // held low: stuck_lo
        pwm_in = 1'b0; step(8300);
        check("tl_stlo", 32'(stuck_lo), 1);
        check("tl_duty", 32'(duty), 0);
        check("tl_period", 32'(period), 0);
        check("tl_sthi", 32'(stuck_hi), 0);
        pwm_in = 1'b1; step(10);
        check("tl_stlo_clr", 32'(stuck_lo), 0);

        // 8-cycle period: every other completion overruns
        rst = 1'b1; step(2);
        rst = 1'b0;
        pwm_in = 1'b0; step(10);
        mark();
        for (int i = 0; i < 6; i++) begin
            pwm_in = 1'b1; step(4);
            pwm_in = 1'b0; step(4);
        end
        pwm_in = 1'b1; step(30);
        check("t4_ovr_cnt", 32'(ovr_cnt - ovr_base), 3);
        check("t4_dv_cnt", 32'(dv_cnt - dv_base), 3);
        check("t4_duty", 32'(last_duty), 512);
        check("t4_period", 32'(period), 8);

        // odd period 30/3000, then reset mid high phase
        pwm_in = 1'b0; step(3000);
        pwm_in = 1'b1; step(20);
        check("t5_pre_duty", 32'(duty), 10);
        check("t5_pre_period", 32'(period), 3030);
        step(480);
        rst = 1'b1;
        #2;
        check("t5_rst_duty", 32'(duty), 0);
        check("t5_rst_period", 32'(period), 0);
        check("t5_rst_dv", 32'(duty_valid), 0);
        check("t5_rst_sthi", 32'(stuck_hi), 0);
        check("t5_rst_stlo", 32'(stuck_lo), 0);
        check("t5_rst_ovr", 32'(overrun), 0);
        step(3);
        rst = 1'b0;
        mark();
        step(500);
        pwm_in = 1'b0; step(3000);
        check("t5_partial_dv", 32'(dv_cnt - dv_base), 0);
        pwm_in = 1'b1; step(1000);
        pwm_in = 1'b0; step(3000);
        pwm_in = 1'b1; step(20);
        check("t5_dv_cnt", 32'(dv_cnt - dv_base), 1);
        check("t5_duty", 32'(duty), 256);
        check("t5_period", 32'(period), 4000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Measures an incoming PWM waveform, such as a motor driver's PWM line looped back or a remote controller's PWM command, and recovers its duty cycle on the same 10-bit scale the motor PWM generator uses (0..1023). It also reports the measured period and flags a line that is stuck high or stuck low. The block sits on the sensing/feedback path beside the motor driver, in the c100MHz domain.

Parameters:
DUTY_W, 10, width of the duty result; full scale is 2^DUTY_W.
MAX_PERIOD_CYC, 8192, count at which a HIGH or LOW phase is declared stuck (timeout).
CNT_W, 14, width of the phase and period counters; must satisfy 2^CNT_W > MAX_PERIOD_CYC.
SYNC_STAGES, 2, number of synchronizer flops on pwm_in.

Ports:
c100MHz  in  1  system clock, 100 MHz.
rst  in  1  reset, asynchronous, active-high.
pwm_in  in  1  PWM input, asynchronous to c100MHz.
duty  out  DUTY_W  last measured duty; registered, holds between updates.
period  out  CNT_W  last measured period in clock cycles.
duty_valid  out  1  one-cycle pulse when duty/period update.
stuck_hi  out  1  level; pwm_in held high for at least MAX_PERIOD_CYC cycles.
stuck_lo  out  1  level; pwm_in held low for at least MAX_PERIOD_CYC cycles.
overrun  out  1  one-cycle pulse when a period completes while the divider is busy.

Behaviour:
- Reset: duty=0, period=0, duty_valid=0, stuck_hi=0, stuck_lo=0, overrun=0, state=WAIT_RISE, counters=0, divider idle.
- pwm_in passes through a SYNC_STAGES flop chain; edges are detected on the synchronized signal (s). Pin-to-edge latency is SYNC_STAGES+1 cycles.
- FSM states: WAIT_RISE, HIGH, LOW, STUCK.
- WAIT_RISE: ignore everything until the rising edge of s, then hi_cnt=1 -> HIGH. The first partial period after reset or recovery is never measured.
- HIGH: hi_cnt++ each cycle. On the falling edge, lo_cnt=1 -> LOW.
- LOW: lo_cnt++ each cycle. On the rising edge, the period completes with P = hi_cnt+lo_cnt and H = hi_cnt; then hi_cnt=1, stay measuring -> HIGH.
- Period complete:
  - If the divider is idle, start it with numerator H<<DUTY_W and denominator P.
  - If the divider is busy, assert overrun for 1 cycle, discard the period, and keep the previous result.
- Divider result:
  - duty = floor(H*2^DUTY_W / P). Since H<P, the result always fits DUTY_W bits.
  - period = P.
  - duty_valid pulses exactly DUTY_W+2 cycles after the rising-edge cycle that completed the period.
- Timeout:
  - If hi_cnt reaches MAX_PERIOD_CYC in HIGH: stuck_hi=1, duty=2^DUTY_W-1, period=0, duty_valid pulse next cycle -> STUCK.
  - If lo_cnt reaches MAX_PERIOD_CYC in LOW or WAIT_RISE: stuck_lo=1, duty=0, period=0, duty_valid pulse -> STUCK.
  - An in-flight divider result is discarded when a timeout fires.
- STUCK:
  - On the rising edge of s, clear both stuck flags, hi_cnt=1 -> HIGH.
  - A falling edge while stuck_hi is set clears stuck_hi and -> WAIT_RISE.
- Counters saturate at 2^CNT_W-1 and never wrap.
- A timeout and an edge in the same cycle: the edge wins.
- rst asserted mid-measurement or mid-division returns everything to reset values immediately; no duty_valid pulse is emitted for the aborted period.

Optional Feature:
PWM_CAPTURE_AVG_EN
- Defined: duty is the truncated average of the last 4 divider results (sum>>2).
  - duty_valid is suppressed until 4 results have been collected since reset or the last timeout.
  - A timeout flushes the history and drives duty directly to 0 or full scale.
  - period always reports the latest raw P.
- Not defined: each divider result drives duty directly, as described in Behaviour.

Decomposition:
- Package pwm_pkg holds:
  - the state enum (WAIT_RISE, HIGH, LOW, STUCK);
  - DUTY_W_DEF=10;
  - DUTY_FULL=1023;
  - CLK_HZ=100_000_000.
- Sub-module pwm_duty_div: restoring sequential unsigned divider.
  - Interface is start/busy/done.
  - Produces one quotient bit per cycle; done DUTY_W+1 cycles after start.
  - Parameterized by quotient and denominator widths.

Test Plan:
- Period 4000 cycles, high 1000, after the first full period -> duty=256, period=4000, duty_valid 12 cycles after the synchronized rise.
- High 2000 / low 2000 repeated 3 times -> three duty_valid pulses, each with duty=512, no overrun.
- pwm_in held high 10000 cycles -> stuck_hi=1 and duty=1023 at hi_cnt=8192; a later rise then fall clears stuck_hi; the next full period is measured normally.
- Period 8 cycles (high 4) -> the first period produces duty=512; following periods that complete while the divider is busy pulse overrun and do not update.
- rst asserted at hi_cnt=500 of a 4000-cycle period -> all outputs 0 and no duty_valid; after release, the first partial period is skipped and the next full period gives the correct duty.
- With PWM_CAPTURE_AVG_EN, duties 256, 256, 512, 512 -> only one duty_valid, after the 4th result, with duty=384.
